cdb_arbiter: RTL and testbench

Shares the single ROB writeback path (ROB position plus 32-bit result) between the execution-side producers: ALU, load/store buffer and branch unit. Each producer gets a one-entry holding buffer. A round-robin arbiter picks one pending result per cycle and drives it as a registered CDB broadcast, consumed by the ROB and the reservation stations. The block sits between the execution units and the ROB's execution-result inputs, and owns the flush behaviour of in-flight results on misprediction.

---
 rtl/cdb_pkg.sv | 17 +
 rtl/rr_pick.sv | 35 +++
 rtl/cdb_arbiter.sv | 112 +++++++++++
 tb/tb_cdb_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared constants and helpers for the CDB writeback arbiter and its pickers.
// Producer indices are fixed: ALU, load/store buffer, branch unit.
package cdb_pkg;

    localparam int DEF_Q_WIDTH = 5;
    localparam int DEF_N_SRC   = 3;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSB = 1;
    localparam int SRC_BR  = 2;

    // Position of the offset-th candidate when scanning a ring of n requesters from start.
    function automatic int ring_index(input int start, input int offset, input int n);
        return (start + offset) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: scans req from start upward (mod N)
// and reports the first hit as a one-hot grant plus its index.
module rr_pick
    import cdb_pkg::*;
#(
    parameter int N = DEF_N_SRC,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] cand;

    // Scan from the farthest candidate back to start so the nearest hit is written last.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = W'(ring_index(int'(start), k, N));
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Single-path CDB writeback arbiter: one holding buffer per producer, registered broadcast.
// Define CDB_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int Q_WIDTH = DEF_Q_WIDTH,
    parameter int N_SRC   = DEF_N_SRC,
    localparam int SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clr_in,
    input  logic [N_SRC-1:0]         src_valid,
    output logic [N_SRC-1:0]         src_ready,
    input  logic [N_SRC*Q_WIDTH-1:0] src_rob_pos,
    input  logic [N_SRC*32-1:0]      src_value,
    output logic                     cdb_valid,
    output logic [Q_WIDTH-1:0]       cdb_rob_pos,
    output logic [31:0]              cdb_value,
    output logic [SRC_W-1:0]         cdb_src
);

    logic [N_SRC-1:0]   buf_valid;
    logic [Q_WIDTH-1:0] buf_pos [N_SRC];
    logic [31:0]        buf_val [N_SRC];

    logic [N_SRC-1:0]   grant;
    logic [N_SRC-1:0]   capture;
    logic [SRC_W-1:0]   win_idx;
    logic [SRC_W-1:0]   pick_start;
    logic               win_found;

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign pick_start = '0;
`else
    logic [SRC_W-1:0] rr_ptr;
    assign pick_start = rr_ptr;
`endif

    rr_pick #(
        .N (N_SRC),
        .W (SRC_W)
    ) u_pick (
        .req   (buf_valid),
        .start (pick_start),
        .grant (grant),
        .idx   (win_idx),
        .found (win_found)
    );

    // Handshake: a result transfers on an edge where src_valid[i] and src_ready[i] are both high.
    // src_ready depends only on buffer state, grant and control inputs, never on src_valid.
    assign src_ready = {N_SRC{rdy_in & ~rst_in & ~clr_in}} & (~buf_valid | grant);
    assign capture   = src_valid & src_ready;

    // A capture into the buffer being granted on the same edge keeps the buffer full.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            buf_valid <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                buf_pos[i] <= '0;
                buf_val[i] <= '0;
            end
        end else if (clr_in) begin
            buf_valid <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (capture[i]) begin
                    buf_valid[i] <= 1'b1;
                    buf_pos[i]   <= src_rob_pos[i*Q_WIDTH +: Q_WIDTH];
                    buf_val[i]   <= src_value[i*32 +: 32];
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Data outputs keep their last broadcast when no grant happens.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cdb_valid   <= 1'b0;
            cdb_rob_pos <= '0;
            cdb_value   <= '0;
            cdb_src     <= '0;
        end else if (clr_in) begin
            cdb_valid <= 1'b0;
        end else if (rdy_in) begin
            if (win_found) begin
                cdb_valid   <= 1'b1;
                cdb_rob_pos <= buf_pos[win_idx];
                cdb_value   <= buf_val[win_idx];
                cdb_src     <= win_idx;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

`ifndef CDB_ARB_FIXED_PRIO_EN
    // The pointer moves past the last winner and holds across flushes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr <= '0;
        end else if (!clr_in && rdy_in && win_found) begin
            rr_ptr <= (win_idx == SRC_W'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: scripted scenarios plus randomized traffic
// checked against a behavioural model of the buffers and the rotating grant.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int QW = DEF_Q_WIDTH;
    localparam int NS = DEF_N_SRC;
    localparam int SW = $clog2(NS);

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              clr_in;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*QW-1:0]  src_rob_pos;
    logic [NS*32-1:0]  src_value;
    logic              cdb_valid;
    logic [QW-1:0]     cdb_rob_pos;
    logic [31:0]       cdb_value;
    logic [SW-1:0]     cdb_src;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_bv [NS];
    logic [QW-1:0] m_bp [NS];
    logic [31:0] m_bd [NS];
    int          m_ptr = 0;
    logic        m_cv = 1'b0;
    logic [QW-1:0] m_cp = '0;
    logic [31:0] m_cd = '0;
    int          m_cs = 0;

    always #5 clk_in = ~clk_in;

    cdb_arbiter dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clr_in      (clr_in),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_rob_pos (src_rob_pos),
        .src_value   (src_value),
        .cdb_valid   (cdb_valid),
        .cdb_rob_pos (cdb_rob_pos),
        .cdb_value   (cdb_value),
        .cdb_src     (cdb_src)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // ---------------- model ----------------
    function automatic int m_winner();
        int start;
`ifdef CDB_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < NS; k++) begin
            if (m_bv[(start + k) % NS]) return (start + k) % NS;
        end
        return -1;
    endfunction

    function automatic logic [NS-1:0] m_ready();
        logic [NS-1:0] r;
        int w;
        w = m_winner();
        for (int i = 0; i < NS; i++)
            r[i] = rdy_in && !rst_in && !clr_in && (!m_bv[i] || w == i);
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        int w;
        logic [NS-1:0] rv;
        rv = m_ready();
        w  = m_winner();
        @(posedge clk_in);
        if (rst_in) begin
            for (int i = 0; i < NS; i++) begin
                m_bv[i] = 0; m_bp[i] = '0; m_bd[i] = '0;
            end
            m_ptr = 0; m_cv = 0; m_cp = '0; m_cd = '0; m_cs = 0;
        end else if (clr_in) begin
            for (int i = 0; i < NS; i++) m_bv[i] = 0;
            m_cv = 0;
        end else if (rdy_in) begin
            if (w >= 0) begin
                m_cv = 1; m_cp = m_bp[w]; m_cd = m_bd[w]; m_cs = w;
                m_bv[w] = 0;
                m_ptr = (w + 1) % NS;
            end else begin
                m_cv = 0;
            end
            for (int i = 0; i < NS; i++) begin
                if (src_valid[i] && rv[i]) begin
                    m_bv[i] = 1;
                    m_bp[i] = src_rob_pos[i*QW +: QW];
                    m_bd[i] = src_value[i*32 +: 32];
                end
            end
        end
        @(negedge clk_in);
    endtask

    task automatic drive(input logic r, input logic c, input logic y, input logic [NS-1:0] v);
        rst_in = r; clr_in = c; rdy_in = y; src_valid = v;
    endtask

    task automatic set_src(input int i, input logic [QW-1:0] p, input logic [31:0] d);
        src_rob_pos[i*QW +: QW] = p;
        src_value[i*32 +: 32]   = d;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b1, '0);
        tick();
        drive(1'b0, 1'b0, 1'b1, '0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1, 3'b111);
        for (int i = 0; i < NS; i++) set_src(i, QW'(i + 5), 32'hdead_0000 + 32'(i));
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (src_ready !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_ready: src_ready=%b, required 000", src_ready);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 3'b000);
        n_checks++;
        if (cdb_valid !== 1'b0 || cdb_src !== '0 || cdb_rob_pos !== '0 || cdb_value !== '0) begin
            n_fail++;
            $display("FAIL reset_cdb: valid=%b src=%0d pos=%0d val=%h, required 0/0/0/0",
                     cdb_valid, cdb_src, cdb_rob_pos, cdb_value);
        end
        #1;
        n_checks++;
        if (src_ready !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_empty_ready: src_ready=%b, required 111", src_ready);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_capture: cdb_valid=%b, required 0", cdb_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 3'b001);
        set_src(SRC_ALU, 5'd3, 32'h11);
        #1;
        n_checks++;
        if (src_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready0: src_ready[0]=%b, required 1", src_ready[0]);
        end
        tick();
        set_src(SRC_ALU, 5'd4, 32'h22);
        #1;
        n_checks++;
        if (src_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready1: src_ready[0]=%b, required 1", src_ready[0]);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_rob_pos !== 5'd3 || cdb_value !== 32'h11 || cdb_src !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b pos=%0d val=%h src=%0d, required 1/3/11/0",
                     cdb_valid, cdb_rob_pos, cdb_value, cdb_src);
        end
        drive(1'b0, 1'b0, 1'b1, 3'b000);
        #1;
        n_checks++;
        if (src_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready2: src_ready[0]=%b, required 1", src_ready[0]);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_rob_pos !== 5'd4 || cdb_value !== 32'h22) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%b pos=%0d val=%h, required 1/4/22",
                     cdb_valid, cdb_rob_pos, cdb_value);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: cdb_valid=%b, required 0", cdb_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            drive(1'b0, 1'b0, 1'b1, 3'b111);
            for (int i = 0; i < NS; i++) set_src(i, QW'(i + 1), 32'h100 * 32'(pass + 1) + 32'(i));
            #1;
            n_checks++;
            if (src_ready !== 3'b111) begin
                n_fail++; $display("FAIL rr_load_ready: src_ready=%b, required 111", src_ready);
            end
            tick();
            drive(1'b0, 1'b0, 1'b1, 3'b000);
            for (int k = 0; k < NS; k++) begin
                tick();
                n_checks++;
                if (cdb_valid !== 1'b1 || cdb_src !== SW'(k) || cdb_rob_pos !== QW'(k + 1)) begin
                    n_fail++;
                    $display("FAIL rr_order: pass=%0d step=%0d valid=%b src=%0d pos=%0d, required 1/%0d/%0d",
                             pass, k, cdb_valid, cdb_src, cdb_rob_pos, k, k + 1);
                end
            end
        end
        // All producers continuously offering results.
        drive(1'b0, 1'b0, 1'b1, 3'b111);
        for (int c = 0; c < 10; c++) begin
            int exp_src;
`ifdef CDB_ARB_FIXED_PRIO_EN
            exp_src = 0;
`else
            exp_src = (c - 1) % NS;
`endif
            for (int i = 0; i < NS; i++) set_src(i, QW'($urandom), $urandom);
            tick();
            if (c >= 1) begin
                n_checks++;
                if (cdb_valid !== 1'b1 || cdb_src !== SW'(exp_src)) begin
                    n_fail++;
                    $display("FAIL rr_continuous: cycle=%0d valid=%b src=%0d, required 1/%0d",
                             c, cdb_valid, cdb_src, exp_src);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b1, 3'b000);
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 3'b001);
        set_src(SRC_ALU, 5'd7, 32'h77);
        tick();
        drive(1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'b010);
        set_src(SRC_LSB, 5'd9, 32'h99);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (src_ready !== 3'b000) begin
                n_fail++; $display("FAIL stall_ready: cycle=%0d src_ready=%b, required 000", c, src_ready);
            end
            tick();
            n_checks++;
            if (cdb_valid !== 1'b1 || cdb_rob_pos !== 5'd7 || cdb_value !== 32'h77 || cdb_src !== 2'd0) begin
                n_fail++;
                $display("FAIL stall_hold: cycle=%0d valid=%b pos=%0d val=%h src=%0d, required 1/7/77/0",
                         c, cdb_valid, cdb_rob_pos, cdb_value, cdb_src);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 3'b010);
        #1;
        n_checks++;
        if (src_ready[1] !== 1'b1) begin
            n_fail++; $display("FAIL stall_resume_ready: src_ready[1]=%b, required 1", src_ready[1]);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_gap: cdb_valid=%b, required 0", cdb_valid);
        end
        drive(1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_rob_pos !== 5'd9 || cdb_value !== 32'h99) begin
            n_fail++;
            $display("FAIL stall_next: valid=%b src=%0d pos=%0d val=%h, required 1/1/9/99",
                     cdb_valid, cdb_src, cdb_rob_pos, cdb_value);
        end
    endtask

    task automatic test_flush();
        int first;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 3'b101);
        set_src(SRC_ALU, 5'd10, 32'h100);
        set_src(SRC_BR, 5'd12, 32'h300);
        tick();
        drive(1'b0, 1'b0, 1'b1, 3'b001);
        set_src(SRC_ALU, 5'd11, 32'h101);
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_rob_pos !== 5'd10) begin
            n_fail++;
            $display("FAIL flush_setup: valid=%b pos=%0d, required 1/10", cdb_valid, cdb_rob_pos);
        end
        drive(1'b0, 1'b1, 1'b1, 3'b010);
        set_src(SRC_LSB, 5'd13, 32'h200);
        #1;
        n_checks++;
        if (src_ready !== 3'b000) begin
            n_fail++; $display("FAIL flush_ready: src_ready=%b, required 000", src_ready);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_cancel: cdb_valid=%b, required 0", cdb_valid);
        end
        drive(1'b0, 1'b0, 1'b1, 3'b000);
        #1;
        n_checks++;
        if (src_ready !== 3'b111) begin
            n_fail++; $display("FAIL flush_empty: src_ready=%b, required 111", src_ready);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_capture: cdb_valid=%b, required 0", cdb_valid);
        end
        // Pointer was 1 before the flush and must still be 1.
`ifdef CDB_ARB_FIXED_PRIO_EN
        first = 0;
`else
        first = 1;
`endif
        drive(1'b0, 1'b0, 1'b1, 3'b111);
        for (int i = 0; i < NS; i++) set_src(i, QW'(20 + i), 32'h500 + 32'(i));
        tick();
        drive(1'b0, 1'b0, 1'b1, 3'b000);
        for (int k = 0; k < NS; k++) begin
            int es;
            es = (first + k) % NS;
            tick();
            n_checks++;
            if (cdb_valid !== 1'b1 || cdb_src !== SW'(es) || cdb_rob_pos !== QW'(20 + es)) begin
                n_fail++;
                $display("FAIL flush_ptr_order: step=%0d valid=%b src=%0d pos=%0d, required 1/%0d/%0d",
                         k, cdb_valid, cdb_src, cdb_rob_pos, es, 20 + es);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int r;
            logic [NS-1:0] er;
            r = $urandom_range(0, 99);
            drive(r < 2, (r >= 2) && (r < 7), $urandom_range(0, 5) != 0, NS'($urandom_range(0, 7)));
            for (int i = 0; i < NS; i++) set_src(i, QW'($urandom), $urandom);
            #1;
            er = m_ready();
            n_checks++;
            if (src_ready !== er) begin
                n_fail++;
                $display("FAIL rand_ready: cycle=%0d src_ready=%b, required %b", c, src_ready, er);
            end
            tick();
            n_checks++;
            if (cdb_valid !== m_cv || cdb_rob_pos !== m_cp || cdb_value !== m_cd || cdb_src !== SW'(m_cs)) begin
                n_fail++;
                $display("FAIL rand_cdb: cycle=%0d got %b/%0d/%h/%0d, required %b/%0d/%h/%0d",
                         c, cdb_valid, cdb_rob_pos, cdb_value, cdb_src, m_cv, m_cp, m_cd, m_cs);
            end
        end
    endtask

    initial begin
        src_rob_pos = '0;
        src_value   = '0;
        drive(1'b1, 1'b0, 1'b1, '0);
        test_reset();
        test_back_to_back();
        test_round_robin();
        test_stall();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
